sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO controller with register-array storage. Depth is a power of two and the data width is configurable. Provides occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and defined behaviour for simultaneous read and write. Sits between a producer and a consumer in the same clk domain, as the general-purpose buffer for the datapath.

Parameters:
WIDTH, 8, data word width in bits
ADDR, 4, address bits; depth DEPTH = 2**ADDR (derived localparam, not overridable)
AF_THRESH, 12, almost_full asserted when count >= AF_THRESH (legal range 1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (legal range 0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cs  in  1  chip select; rd and we are ignored when low
we  in  1  write request
rd  in  1  read request
clr_err  in  1  clears the overflow and underflow flags
data_in  in  WIDTH  write data
data_out  out  WIDTH  read data
empty  out  1  FIFO holds 0 words
full  out  1  FIFO holds DEPTH words
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (reset==0 at posedge): wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not reset. Reset mid-operation discards all stored data.
- Pointers: ADDR+1 bits each; the low ADDR bits index memory; wrap is natural modulo 2**(ADDR+1), with no compare-to-constant wrap logic.
- Read accept: rd_acc = cs & rd & !empty.
- Write accept: wr_acc = cs & we & (!full | rd_acc). A write into a full FIFO succeeds only if a read is accepted in the same cycle.
- Empty FIFO with rd & we in the same cycle: the write is accepted and the read is rejected (no bypass path). underflow sets.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr++.
- On rd_acc: data_out <= mem[rd_ptr] (1-cycle latency); rd_ptr++. data_out holds its value when there is no accepted read.
- Count update: count_next = count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- All flags are registered and computed from count_next, so they are valid in the same cycle as count: empty=(count_next==0), full=(count_next==DEPTH), almost_full=(count_next>=AF_THRESH), almost_empty=(count_next<=AE_THRESH).
- Error flags:
  - overflow sets when cs & we & !wr_acc.
  - underflow sets when cs & rd & !rd_acc.
  - Both clear when clr_err==1.
  - If set and clear occur in the same cycle, set wins.
  - Neither flag changes stored data or pointers.
- cs==0: no pointer, memory, count or error-flag change.

Optional Feature:
FIFO_FWFT_EN: first-word-fall-through mode.
- Defined: data_out = mem[rd_ptr[ADDR-1:0]] combinationally. data_out is valid whenever empty==0, and rd_acc pops the head word. A word written into an empty FIFO is visible on data_out the cycle after the write, when empty deasserts. data_out is undefined when empty==1, and the reset value of the data_out register does not apply.
- Undefined: standard mode as described above, with registered data_out and 1-cycle read latency.

Test Plan:
- Reset, then write 0x01..0x10 (16 words, defaults) -> full=1 after the 16th write, almost_full=1 from count=12, count=16. A 17th write is rejected: overflow=1, count stays 16.
- Read 16 words from full -> data_out 0x01..0x10 in order, each one cycle after rd (standard mode). empty=1 after the last read, almost_empty=1 at count<=2. A further rd sets underflow=1 and data_out stays 0x10.
- Full FIFO, simultaneous rd & we with data_in=0xAA -> both accepted, count stays 16, full stays 1. 0xAA is read out last, after 15 more reads.
- Empty FIFO, simultaneous rd & we with data_in=0x55 -> write accepted, read rejected, count=1, underflow=1, empty=0 next cycle.
- Write/read 40 words while holding count between 3 and 5 -> pointer wrap verified, data order intact, no error flags. Then set overflow and apply clr_err together with a rejected write -> overflow stays 1. Apply clr_err alone -> overflow=0.
- Drive reset=0 for one cycle with count=7 -> count=0, empty=1, data_out=0, flags cleared. With FIFO_FWFT_EN: write 0x3C to the empty FIFO -> data_out=0x3C the next cycle with no rd.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller over a register array with occupancy, threshold and sticky error flags.
// Read latency: one cycle (registered data_out); with FIFO_FWFT_EN defined the head word is shown combinationally.
// Backpressure: writes into a full FIFO are rejected unless a read is accepted in the same cycle; rejected requests set sticky flags.
module sync_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ADDR      = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             we,
    input  logic             rd,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            DEPTH = 1 << ADDR;
    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] AF_C    = (ADDR+1)'(AF_THRESH);
    localparam logic [ADDR:0] AE_C    = (ADDR+1)'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR:0]    wr_ptr;
    logic [ADDR:0]    rd_ptr;
    logic [ADDR:0]    count_next;
    logic             rd_acc;
    logic             wr_acc;
    logic             ovf_set;
    logic             unf_set;
    logic             err_clr;

    // An empty FIFO never forwards write data to a same-cycle read.
    assign rd_acc  = cs & rd & ~empty;
    assign wr_acc  = cs & we & (~full | rd_acc);
    assign ovf_set = cs & we & ~wr_acc;
    assign unf_set = cs & rd & ~rd_acc;
    assign err_clr = cs & clr_err;

    assign count_next = count + (ADDR+1)'(wr_acc) - (ADDR+1)'(rd_acc);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
        end
    end

    // Set takes priority over clear so a same-cycle rejection is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow  & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR-1:0]] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = mem[rd_ptr[ADDR-1:0]];
`else
    logic [WIDTH-1:0] data_out_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_r <= '0;
        end else if (rd_acc) begin
            data_out_r <= mem[rd_ptr[ADDR-1:0]];
        end
    end

    assign data_out = data_out_r;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at default parameters (DEPTH 16, AF 12, AE 2).
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       cs;
    logic       we;
    logic       rd;
    logic       clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int vectors;
    int miscompares;

    sync_fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .we           (we),
        .rd           (rd),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given request; inputs change 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        cs      = 1'b1;
        we      = w;
        rd      = r;
        clr_err = c;
        data_in = d;
        @(posedge clk);
        #1;
        we      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got %b want 1", almost_empty); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %b want 0", almost_full); end
        vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
`ifndef FIFO_FWFT_EN
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h want 00", data_out); end
`endif
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            vectors++; if (count !== 5'(i)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
            vectors++; if (almost_full !== (i >= 12)) begin miscompares++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i >= 12)); end
            vectors++; if (full !== (i == 16)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 16)); end
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h99);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fill_ovf got %b want 1", overflow); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_ovf_count got %0d want 16", count); end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_FWFT_EN
            vectors++; if (data_out !== 8'(i)) begin miscompares++; $display("FAIL drain_dout[%0d] got %h want %h", i, data_out, 8'(i)); end
`endif
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
            vectors++; if (data_out !== 8'(i)) begin miscompares++; $display("FAIL drain_dout[%0d] got %h want %h", i, data_out, 8'(i)); end
`endif
            vectors++; if (count !== 5'(16 - i)) begin miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 16 - i); end
            vectors++; if (almost_empty !== ((16 - i) <= 2)) begin miscompares++; $display("FAIL drain_ae[%0d] got %b want %b", i, almost_empty, ((16 - i) <= 2)); end
            vectors++; if (empty !== (i == 16)) begin miscompares++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty, (i == 16)); end
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL drain_unf got %b want 1", underflow); end
`ifndef FIFO_FWFT_EN
        vectors++; if (data_out !== 8'h10) begin miscompares++; $display("FAIL drain_hold got %h want 10", data_out); end
`endif
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL drain_clr got %b%b want 00", overflow, underflow); end
    endtask

    task automatic test_full_rdwr;
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        cyc(1'b1, 1'b1, 1'b0, 8'hAA);
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL frw_count got %0d want 16", count); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL frw_full got %b want 1", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL frw_ovf got %b want 0", overflow); end
`ifndef FIFO_FWFT_EN
        vectors++; if (data_out !== 8'h20) begin miscompares++; $display("FAIL frw_dout got %h want 20", data_out); end
`endif
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp;
            exp = (i == 16) ? 8'hAA : 8'(8'h20 + i);
`ifdef FIFO_FWFT_EN
            vectors++; if (data_out !== exp) begin miscompares++; $display("FAIL frw_rd[%0d] got %h want %h", i, data_out, exp); end
`endif
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
            vectors++; if (data_out !== exp) begin miscompares++; $display("FAIL frw_rd[%0d] got %h want %h", i, data_out, exp); end
`endif
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL frw_empty got %b want 1", empty); end
    endtask

    task automatic test_empty_rdwr;
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL erw_count got %0d want 1", count); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL erw_unf got %b want 1", underflow); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL erw_empty got %b want 0", empty); end
`ifdef FIFO_FWFT_EN
        vectors++; if (data_out !== 8'h55) begin miscompares++; $display("FAIL erw_dout got %h want 55", data_out); end
`endif
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
        vectors++; if (data_out !== 8'h55) begin miscompares++; $display("FAIL erw_dout got %h want 55", data_out); end
`endif
        vectors++; if ({empty, underflow} !== 2'b10) begin miscompares++; $display("FAIL erw_after got %b%b want 10", empty, underflow); end
    endtask

    // Writes run ahead of reads by 3..5 words so both pointers wrap with live data.
    task automatic test_wrap;
        logic [7:0] q[$];
        logic [7:0] exp;
        logic [7:0] nxt;
        nxt = 8'h80;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, nxt); q.push_back(nxt); nxt++;
        end
        for (int k = 0; k < 80; k++) begin
            if (k % 4 < 2) begin
                cyc(1'b1, 1'b0, 1'b0, nxt); q.push_back(nxt); nxt++;
            end else begin
                exp = q.pop_front();
`ifdef FIFO_FWFT_EN
                vectors++; if (data_out !== exp) begin miscompares++; $display("FAIL wrap_dout[%0d] got %h want %h", k, data_out, exp); end
`endif
                cyc(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
                vectors++; if (data_out !== exp) begin miscompares++; $display("FAIL wrap_dout[%0d] got %h want %h", k, data_out, exp); end
`endif
            end
            vectors++; if (count !== 5'(q.size())) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d want %0d", k, count, q.size()); end
            vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL wrap_err[%0d] got %b%b want 00", k, overflow, underflow); end
        end
    endtask

    task automatic test_clr_err;
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL clr_full got %b want 1", full); end
        cyc(1'b1, 1'b0, 1'b0, 8'hEE);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL clr_set got %b want 1", overflow); end
        cyc(1'b1, 1'b0, 1'b1, 8'hEE);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL clr_setwins got %b want 1", overflow); end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_alone got %b want 0", overflow); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL clr_count got %0d want 16", count); end
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++; if (count !== 5'd7) begin miscompares++; $display("FAIL rmid_pre_count got %0d want 7", count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_ovf got %b want 1", overflow); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rmid_count got %0d want 0", count); end
        vectors++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin miscompares++; $display("FAIL rmid_flags got %b want 1010", {empty, full, almost_empty, almost_full}); end
        vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL rmid_err got %b%b want 00", overflow, underflow); end
`ifndef FIFO_FWFT_EN
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL rmid_dout got %h want 00", data_out); end
`endif
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft;
        cyc(1'b1, 1'b0, 1'b0, 8'h3C);
        vectors++; if (data_out !== 8'h3C) begin miscompares++; $display("FAIL fwft_dout got %h want 3c", data_out); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fwft_empty got %b want 0", empty); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b0;
        cs      = 1'b0;
        we      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        data_in = 8'h00;
        #2;
        test_reset;
        test_fill;
        test_drain;
        test_full_rdwr;
        test_empty_rdwr;
        test_wrap;
        test_clr_err;
        test_reset_mid;
`ifdef FIFO_FWFT_EN
        test_fwft;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
